// File: rtl/harness_ctrl.sv
// harness_ctrl: test-harness sequencer. Drives staggered resets into the Core's
// sub-blocks, counts run cycles, watches tohost for the pass/fail handshake,
// enforces a run-cycle watchdog and gates waveform dumping to the run phase.
module harness_ctrl #(
  parameter int NUM_RST     = 2,
  parameter int RST_HOLD    = 5,
  parameter int RST_STAGGER = 2,
  parameter int TIMEOUT     = 100000,
  parameter int CNT_W       = 32,
  parameter int DATA_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tohost_valid,
  input  logic [DATA_W-1:0]  tohost_data,
  output logic [NUM_RST-1:0] rst_out,
  output logic               dump_en,
  output logic [CNT_W-1:0]   cycle_count,
  output logic               done,
  output logic               pass,
  output logic [DATA_W-2:0]  fail_code,
  output logic               timeout
);

  // Last counter value of each sequencing phase; the shared counter is sized
  // for whichever phase runs longer.
  localparam int HOLD_LAST = RST_HOLD - 1;
  localparam int REL_LAST  = (NUM_RST - 1) * RST_STAGGER;
  localparam int CTR_MAX   = (HOLD_LAST > REL_LAST) ? HOLD_LAST : REL_LAST;
  localparam int CTR_W     = (CTR_MAX < 2) ? 1 : $clog2(CTR_MAX + 1);

  // Watchdog compare value, in cycle-counter width; unused when TIMEOUT is 0.
  localparam bit               WDOG_EN      = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = WDOG_EN ? CNT_W'(TIMEOUT - 1) : '0;

  if (NUM_RST < 1 || RST_HOLD < 1 || RST_STAGGER < 0 || DATA_W < 2 || TIMEOUT < 0)
  begin : g_bad_cfg
    $error("harness_ctrl: illegal parameter combination");
  end

  if (CNT_W < 63 && (longint'(TIMEOUT) > ((longint'(1) << CNT_W) - 1)))
  begin : g_bad_timeout
    $error("harness_ctrl: TIMEOUT does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [NUM_RST-1:0] rst_out_q, rst_out_d;
  logic               dump_en_q, dump_en_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [DATA_W-2:0]  fail_code_q, fail_code_d;
  logic               timeout_q, timeout_d;
  logic               finish_req;

  // Cycle counter increment that sticks at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign finish_req = tohost_valid & tohost_data[0];

  // Next-state and next-output logic for the harness sequencer.
  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    rst_out_d     = rst_out_q;
    dump_en_d     = dump_en_q;
    cycle_count_d = cycle_count_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_code_d   = fail_code_q;
    timeout_d     = timeout_q;

    unique case (state_q)
      ST_HOLD: begin
        ctr_d = ctr_q + CTR_W'(1);
        if (ctr_q == CTR_W'(HOLD_LAST)) begin
          state_d = ST_RELEASE;
          ctr_d   = '0;
        end
      end

      ST_RELEASE: begin
        ctr_d = ctr_q + CTR_W'(1);
        for (int i = 0; i < NUM_RST; i++) begin
          if (ctr_q == CTR_W'(i * RST_STAGGER)) rst_out_d[i] = 1'b0;
        end
        if (ctr_q == CTR_W'(REL_LAST)) begin
          state_d   = ST_RUN;
          ctr_d     = '0;
          dump_en_d = 1'b1;
        end
      end

      ST_RUN: begin
        cycle_count_d = sat_inc(cycle_count_q);
        // A finishing tohost write takes priority over the watchdog.
        if (finish_req) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          dump_en_d   = 1'b0;
          fail_code_d = tohost_data[DATA_W-1:1];
          pass_d      = (tohost_data[DATA_W-1:1] == '0);
          timeout_d   = 1'b0;
        end else if (WDOG_EN && cycle_count_q == TIMEOUT_LAST) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          dump_en_d   = 1'b0;
          fail_code_d = '0;
          pass_d      = 1'b0;
          timeout_d   = 1'b1;
        end
      end

      ST_DONE: begin
        dump_en_d = 1'b0;
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // State and output registers; reset restarts the whole sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HOLD;
      ctr_q         <= '0;
      rst_out_q     <= '1;
      dump_en_q     <= 1'b0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_code_q   <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      rst_out_q     <= rst_out_d;
      dump_en_q     <= dump_en_d;
      cycle_count_q <= cycle_count_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_code_q   <= fail_code_d;
      timeout_q     <= timeout_d;
    end
  end

  assign rst_out     = rst_out_q;
  assign dump_en     = dump_en_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fail_code_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_harness_ctrl.sv
// Bench for harness_ctrl: five configurations share one stimulus stream and are
// checked every cycle against an edge-count model, plus literal spot checks.
module tb_harness_ctrl;

  localparam int NI       = 5;
  localparam int RST_HOLD = 5;
  // Per-instance configuration: NUM_RST, RST_STAGGER, TIMEOUT, CNT_W.
  localparam int P_NUM  [NI] = '{2, 2, 4, 1, 2};
  localparam int P_STAG [NI] = '{2, 2, 3, 0, 2};
  localparam int P_TO   [NI] = '{100000, 20, 100000, 100000, 0};
  localparam int P_CW   [NI] = '{32, 32, 32, 32, 4};

  logic        clk;
  logic        reset;
  logic        tv;
  logic [31:0] td;

  logic [1:0]  rst0, rst1, rst4;
  logic [3:0]  rst2;
  logic [0:0]  rst3;
  logic [31:0] cc0, cc1, cc2, cc3;
  logic [3:0]  cc4;
  logic [NI-1:0] a_dump, a_done, a_pass, a_to;
  logic [30:0] a_code [NI];
  logic [3:0]  a_rst  [NI];
  logic [31:0] a_cc   [NI];

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 0;

  // Model state: edges since reset release plus per-instance finish record.
  int          n = 0;
  bit          m_done [NI];
  bit          m_pass [NI];
  bit          m_to   [NI];
  logic [30:0] m_code [NI];
  longint      m_cc   [NI];

  harness_ctrl #(.NUM_RST(2), .RST_HOLD(RST_HOLD), .RST_STAGGER(2), .TIMEOUT(100000), .CNT_W(32), .DATA_W(32)) dut0 (
    .clk(clk), .reset(reset), .tohost_valid(tv), .tohost_data(td), .rst_out(rst0), .dump_en(a_dump[0]),
    .cycle_count(cc0), .done(a_done[0]), .pass(a_pass[0]), .fail_code(a_code[0]), .timeout(a_to[0]));
  harness_ctrl #(.NUM_RST(2), .RST_HOLD(RST_HOLD), .RST_STAGGER(2), .TIMEOUT(20), .CNT_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .reset(reset), .tohost_valid(tv), .tohost_data(td), .rst_out(rst1), .dump_en(a_dump[1]),
    .cycle_count(cc1), .done(a_done[1]), .pass(a_pass[1]), .fail_code(a_code[1]), .timeout(a_to[1]));
  harness_ctrl #(.NUM_RST(4), .RST_HOLD(RST_HOLD), .RST_STAGGER(3), .TIMEOUT(100000), .CNT_W(32), .DATA_W(32)) dut2 (
    .clk(clk), .reset(reset), .tohost_valid(tv), .tohost_data(td), .rst_out(rst2), .dump_en(a_dump[2]),
    .cycle_count(cc2), .done(a_done[2]), .pass(a_pass[2]), .fail_code(a_code[2]), .timeout(a_to[2]));
  harness_ctrl #(.NUM_RST(1), .RST_HOLD(RST_HOLD), .RST_STAGGER(0), .TIMEOUT(100000), .CNT_W(32), .DATA_W(32)) dut3 (
    .clk(clk), .reset(reset), .tohost_valid(tv), .tohost_data(td), .rst_out(rst3), .dump_en(a_dump[3]),
    .cycle_count(cc3), .done(a_done[3]), .pass(a_pass[3]), .fail_code(a_code[3]), .timeout(a_to[3]));
  harness_ctrl #(.NUM_RST(2), .RST_HOLD(RST_HOLD), .RST_STAGGER(2), .TIMEOUT(0), .CNT_W(4), .DATA_W(32)) dut4 (
    .clk(clk), .reset(reset), .tohost_valid(tv), .tohost_data(td), .rst_out(rst4), .dump_en(a_dump[4]),
    .cycle_count(cc4), .done(a_done[4]), .pass(a_pass[4]), .fail_code(a_code[4]), .timeout(a_to[4]));

  assign a_rst[0] = {2'b00, rst0};
  assign a_rst[1] = {2'b00, rst1};
  assign a_rst[2] = rst2;
  assign a_rst[3] = {3'b000, rst3};
  assign a_rst[4] = {2'b00, rst4};
  assign a_cc[0]  = cc0;
  assign a_cc[1]  = cc1;
  assign a_cc[2]  = cc2;
  assign a_cc[3]  = cc3;
  assign a_cc[4]  = {28'd0, cc4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge on which instance i enters the run phase (counted from reset release).
  function automatic int run_edge(input int i);
    return RST_HOLD + 1 + (P_NUM[i] - 1) * P_STAG[i];
  endfunction

  // Channel j is released on edge RST_HOLD+1+j*stagger.
  function automatic logic [3:0] exp_rst(input int i);
    logic [3:0] r;
    r = '0;
    for (int j = 0; j < P_NUM[i]; j++)
      r[j] = reset ? 1'b1 : (n < RST_HOLD + 1 + j * P_STAG[i]);
    return r;
  endfunction

  // Model update at each clock edge.
  always @(posedge clk) begin
    if (reset) begin
      n = 0;
      for (int i = 0; i < NI; i++) begin
        m_done[i] = 0; m_pass[i] = 0; m_to[i] = 0; m_code[i] = '0; m_cc[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (!m_done[i] && n >= run_edge(i)) begin
          longint old_cc;
          longint cmax;
          old_cc = m_cc[i];
          cmax = (longint'(1) << P_CW[i]) - 1;
          if (m_cc[i] < cmax) m_cc[i] = m_cc[i] + 1;
          if (tv && td[0]) begin
            m_done[i] = 1;
            m_code[i] = td[31:1];
            m_pass[i] = (td[31:1] == 31'd0);
          end else if (P_TO[i] != 0 && old_cc == longint'(P_TO[i] - 1)) begin
            m_done[i] = 1;
            m_to[i] = 1;
          end
        end
      end
      n = n + 1;
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("d%0d.rst_out", i), a_rst[i], exp_rst(i));
        check($sformatf("d%0d.dump_en", i), a_dump[i], !reset && n >= run_edge(i) && !m_done[i]);
        check($sformatf("d%0d.cycle_count", i), a_cc[i], reset ? 64'd0 : m_cc[i]);
        check($sformatf("d%0d.done", i), a_done[i], !reset && m_done[i]);
        check($sformatf("d%0d.pass", i), a_pass[i], !reset && m_pass[i]);
        check($sformatf("d%0d.fail_code", i), a_code[i], reset ? 31'd0 : m_code[i]);
        check($sformatf("d%0d.timeout", i), a_to[i], !reset && m_to[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic edges(input int k);
    repeat (k) tick();
  endtask

  // One tohost write presented for exactly one edge.
  task automatic write(input logic [31:0] d);
    tv = 1'b1;
    td = d;
    tick();
    tv = 1'b0;
    td = '0;
  endtask

  // Assert reset between edges, hold it over one edge, release it.
  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tv = 1'b0;
    td = '0;
    tick();
    chk_en = 1;
    check("rst_rst_out", rst0, 2'b11);
    check("rst_dump_en", a_dump[0], 1'b0);
    check("rst_cycle_count", cc0, 32'd0);
    check("rst_done", a_done[0], 1'b0);
    tick();
    reset = 1'b0;

    // Reset release and staggered channel release.
    edges(5);
    check("e5_rst_out", rst0, 2'b11);
    check("e5_single_rst", rst3, 1'b1);
    tick();
    check("e6_rst_out", rst0, 2'b10);
    check("e6_sweepA_rst", rst2, 4'b1110);
    check("e6_single_rst", rst3, 1'b0);
    check("e6_single_dump", a_dump[3], 1'b1);
    check("e6_dump_en", a_dump[0], 1'b0);
    edges(2);
    check("e8_rst_out", rst0, 2'b00);
    check("e8_dump_en", a_dump[0], 1'b1);
    tick();
    check("e9_sweepA_rst", rst2, 4'b1100);
    edges(3);
    check("e12_sweepA_rst", rst2, 4'b1000);
    check("e12_sweepA_dump", a_dump[2], 1'b0);
    edges(3);
    check("e15_sweepA_rst", rst2, 4'b0000);
    check("e15_sweepA_dump", a_dump[2], 1'b1);
    edges(2);
    write(32'h1);
    check("pass_done", a_done[0], 1'b1);
    check("pass_pass", a_pass[0], 1'b1);
    check("pass_code", a_code[0], 31'd0);
    check("pass_timeout", a_to[0], 1'b0);
    check("pass_cycle_count", cc0, 32'd10);
    check("pass_dump_en", a_dump[0], 1'b0);
    write(32'h7);
    check("sticky_pass", a_pass[0], 1'b1);
    check("sticky_cc", cc0, 32'd10);

    // Ignored writes in HOLD and with bit0 clear, then a failing code.
    restart();
    edges(2);
    write(32'h7);
    check("hold_write_done", a_done[0], 1'b0);
    edges(13);
    write(32'h2);
    check("syscall_done", a_done[0], 1'b0);
    check("syscall_cc", cc0, 32'd9);
    edges(2);
    write(32'h7);
    check("fail_done", a_done[0], 1'b1);
    check("fail_pass", a_pass[0], 1'b0);
    check("fail_code", a_code[0], 31'd3);
    check("fail_cc", cc0, 32'd12);
    tick();
    write(32'h1);
    check("fail_sticky_pass", a_pass[0], 1'b0);
    check("fail_sticky_code", a_code[0], 31'd3);
    check("fail_sticky_cc", cc0, 32'd12);

    // Watchdog, saturation and asynchronous reset in RUN.
    restart();
    edges(28);
    check("wdog_done", a_done[1], 1'b1);
    check("wdog_timeout", a_to[1], 1'b1);
    check("wdog_pass", a_pass[1], 1'b0);
    check("wdog_cc", cc1, 32'd20);
    check("nowdog_done", a_done[0], 1'b0);
    edges(5);
    check("wdog_frozen_cc", cc1, 32'd20);
    edges(25);
    check("run50_cc", cc0, 32'd50);
    check("sat_cc", cc4, 4'hf);
    check("wdog_off_done", a_done[4], 1'b0);
    reset = 1'b1;
    #1;
    check("async_rst_out", rst0, 2'b11);
    check("async_sweepA_rst", rst2, 4'hf);
    check("async_dump_en", a_dump[0], 1'b0);
    check("async_cc", cc0, 32'd0);
    check("async_timeout", a_to[1], 1'b0);
    tick();
    reset = 1'b0;

    // Full sequence repeats; a finish on the watchdog edge wins over timeout.
    edges(8);
    check("rerun_rst_out", rst0, 2'b00);
    check("rerun_dump_en", a_dump[0], 1'b1);
    check("rerun_cc", cc0, 32'd0);
    edges(19);
    write(32'h1);
    check("race_done", a_done[1], 1'b1);
    check("race_timeout", a_to[1], 1'b0);
    check("race_pass", a_pass[1], 1'b1);
    check("race_cc", cc1, 32'd20);
    edges(3);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
